// File: rtl/ppu_pkg.sv
// Shared constants and types for the sprite tile evaluator.
package ppu_pkg;

  // Byte offsets inside one 4-byte OAM entry
  localparam logic [1:0] OAM_BYTE_Y    = 2'd0;
  localparam logic [1:0] OAM_BYTE_TILE = 2'd1;
  localparam logic [1:0] OAM_BYTE_ATTR = 2'd2;
  localparam logic [1:0] OAM_BYTE_X    = 2'd3;

  // Evaluator FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // Sprite heights in scanlines, sized for the 10-bit row difference
  localparam logic [9:0] SPR_HEIGHT_8  = 10'd8;
  localparam logic [9:0] SPR_HEIGHT_16 = 10'd16;

  // One OAM entry in memory byte order
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
  } sprite_t;

endpackage

// File: rtl/ppu_sprite_overlap.sv
// Combinational test: does a sprite at (Y, X) cover the given row and
// overlap the 8-pixel column span starting at col? All arithmetic is
// 10-bit so Y=255 or X near 255 can never wrap into a false hit.
module ppu_sprite_overlap
  import ppu_pkg::*;
(
  input  logic [8:0] row,
  input  logic [8:0] col,
  input  logic [7:0] spr_y,
  input  logic [7:0] spr_x,
  input  logic       size16,
  output logic       hit
);

  logic [9:0]        row_diff;
  logic [9:0]        height;
  logic              row_hit;
  logic signed [9:0] col_val;
  logic signed [9:0] x_val;
  logic signed [9:0] col_end;
  logic signed [9:0] x_end;
  logic              col_hit;

  // Row and column overlap with sign-aware 10-bit compares
  always_comb begin
    row_diff = {1'b0, row} - {2'b00, spr_y};
    height   = size16 ? SPR_HEIGHT_16 : SPR_HEIGHT_8;
    row_hit  = !row_diff[9] && (row_diff < height);
    col_val  = $signed({col[8], col});
    x_val    = $signed({2'b00, spr_x});
    col_end  = col_val + 10'sd7;
    x_end    = x_val + 10'sd7;
    col_hit  = (x_val <= col_end) && (x_end >= col_val);
    hit      = row_hit && col_hit;
  end

endmodule

// File: rtl/ppu_sprite_tile_eval.sv
// Scans OAM for the first two sprites touching one 8-pixel tile span and
// publishes them (plus an overflow flag) to the tile load stage. Results
// are built in shadow registers and copied out only at COMMIT, so the
// published outputs stay stable while the next tile is evaluated.
module ppu_sprite_tile_eval
  import ppu_pkg::*;
#(
  parameter int NUM_SPRITES = 64,
  parameter int OAM_LATENCY = 2
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] curr_row,
  input  logic [8:0] curr_col,
  input  logic [7:0] ppu_ctrl1,
  input  logic [7:0] ppu_ctrl2,
  output logic [7:0] oam_addr,
  input  logic [7:0] oam_data_in,
  output logic       sprite_0_on_tile,
  output logic       sprite_1_on_tile,
  output logic [7:0] sprite_0_tile_num,
  output logic [7:0] sprite_0_row,
  output logic [7:0] sprite_0_col,
  output logic [7:0] sprite_0_attr,
  output logic [7:0] sprite_1_tile_num,
  output logic [7:0] sprite_1_row,
  output logic [7:0] sprite_1_col,
  output logic [7:0] sprite_1_attr,
  output logic       sprite_overflow,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] ADDR_LAST = 8'(NUM_SPRITES * 4 - 1);
  localparam int         DCW       = $clog2(OAM_LATENCY + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(OAM_LATENCY - 1);

  logic [1:0]     state_reg;
  logic [8:0]     row_reg;
  logic [8:0]     col_reg;
  logic           size16_reg;
  logic [DCW-1:0] drain_cnt_reg;

  // Tag pipeline: which byte of an entry is on oam_data_in this cycle
  logic [OAM_LATENCY-1:0] tag_v_reg;
  logic [1:0]             tag_reg [OAM_LATENCY];

  // Staging entry and shadow result
  logic [7:0] stage_y_reg;
  logic [7:0] stage_tile_reg;
  logic [7:0] stage_attr_reg;
  sprite_t    slot0_reg;
  sprite_t    slot1_reg;
  logic       slot0_v_reg;
  logic       slot1_v_reg;
  logic       ovf_reg;
  logic [1:0] hit_cnt_reg;

  logic       start_accept;
  logic       in_scan;
  logic       ret_valid;
  logic [1:0] ret_tag;
  logic       x_ret;
  logic       overlap_hit;
  logic       eval_hit;
  logic       overflow_exit;
  logic       issue;
  logic [1:0] issue_byte;
  logic       flush;

  ppu_sprite_overlap u_overlap (
    .row    (row_reg),
    .col    (col_reg),
    .spr_y  (stage_y_reg),
    .spr_x  (oam_data_in),
    .size16 (size16_reg),
    .hit    (overlap_hit)
  );

  // Control decode: byte returns, hit evaluation, address issue
  always_comb begin
    start_accept  = (state_reg == ST_IDLE) && start;
    in_scan       = (state_reg == ST_SCAN) || (state_reg == ST_DRAIN);
    ret_valid     = tag_v_reg[OAM_LATENCY-1];
    ret_tag       = tag_reg[OAM_LATENCY-1];
    x_ret         = in_scan && ret_valid && (ret_tag == OAM_BYTE_X);
    eval_hit      = x_ret && overlap_hit;
    overflow_exit = eval_hit && (hit_cnt_reg == 2'd2);
    issue         = (start_accept && ppu_ctrl2[4]) ||
                    ((state_reg == ST_SCAN) && (oam_addr != ADDR_LAST) && !overflow_exit);
    issue_byte    = start_accept ? OAM_BYTE_Y : (oam_addr[1:0] + 2'd1);
    flush         = start_accept || overflow_exit;
  end

  // Byte-tag shift register aligned to the OAM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OAM_LATENCY; i++) begin
        tag_v_reg[i] <= 1'b0;
        tag_reg[i]   <= 2'd0;
      end
    end else begin
      tag_v_reg[0] <= issue;
      tag_reg[0]   <= issue_byte;
      for (int i = 1; i < OAM_LATENCY; i++) begin
        tag_v_reg[i] <= flush ? 1'b0 : tag_v_reg[i-1];
        tag_reg[i]   <= tag_reg[i-1];
      end
    end
  end

  // Main FSM: address sequencing, drain wait, early overflow exit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      oam_addr      <= 8'd0;
      row_reg       <= 9'd0;
      col_reg       <= 9'd0;
      size16_reg    <= 1'b0;
      drain_cnt_reg <= '0;
      busy          <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            row_reg    <= curr_row;
            col_reg    <= curr_col;
            size16_reg <= ppu_ctrl1[5];
            oam_addr   <= 8'd0;
            busy       <= 1'b1;
            state_reg  <= ppu_ctrl2[4] ? ST_SCAN : ST_COMMIT;
          end
        end
        ST_SCAN: begin
          if (overflow_exit) begin
            state_reg <= ST_COMMIT;
          end else if (oam_addr == ADDR_LAST) begin
            drain_cnt_reg <= '0;
            state_reg     <= ST_DRAIN;
          end else begin
            oam_addr <= oam_addr + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (overflow_exit || (drain_cnt_reg == DRAIN_LAST)) begin
            state_reg <= ST_COMMIT;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Staging entry capture and shadow slot fill in OAM index order
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_y_reg    <= 8'd0;
      stage_tile_reg <= 8'd0;
      stage_attr_reg <= 8'd0;
      slot0_reg      <= '0;
      slot1_reg      <= '0;
      slot0_v_reg    <= 1'b0;
      slot1_v_reg    <= 1'b0;
      ovf_reg        <= 1'b0;
      hit_cnt_reg    <= 2'd0;
    end else if (start_accept) begin
      slot0_reg   <= '0;
      slot1_reg   <= '0;
      slot0_v_reg <= 1'b0;
      slot1_v_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      hit_cnt_reg <= 2'd0;
    end else if (in_scan && ret_valid) begin
      case (ret_tag)
        OAM_BYTE_Y:    stage_y_reg    <= oam_data_in;
        OAM_BYTE_TILE: stage_tile_reg <= oam_data_in;
        OAM_BYTE_ATTR: stage_attr_reg <= oam_data_in;
        default: begin
          if (eval_hit) begin
            case (hit_cnt_reg)
              2'd0: begin
                slot0_reg   <= '{y: stage_y_reg, tile: stage_tile_reg,
                                 attr: stage_attr_reg, x: oam_data_in};
                slot0_v_reg <= 1'b1;
                hit_cnt_reg <= 2'd1;
              end
              2'd1: begin
                slot1_reg   <= '{y: stage_y_reg, tile: stage_tile_reg,
                                 attr: stage_attr_reg, x: oam_data_in};
                slot1_v_reg <= 1'b1;
                hit_cnt_reg <= 2'd2;
              end
              default: begin
                ovf_reg     <= 1'b1;
                hit_cnt_reg <= 2'd3;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Published result: updated only at COMMIT, with a one-cycle done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done              <= 1'b0;
      sprite_0_on_tile  <= 1'b0;
      sprite_0_tile_num <= 8'd0;
      sprite_0_row      <= 8'd0;
      sprite_0_col      <= 8'd0;
      sprite_0_attr     <= 8'd0;
      sprite_1_on_tile  <= 1'b0;
      sprite_1_tile_num <= 8'd0;
      sprite_1_row      <= 8'd0;
      sprite_1_col      <= 8'd0;
      sprite_1_attr     <= 8'd0;
      sprite_overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_reg == ST_COMMIT) begin
        done              <= 1'b1;
        sprite_0_on_tile  <= slot0_v_reg;
        sprite_0_tile_num <= slot0_reg.tile;
        sprite_0_row      <= slot0_reg.y;
        sprite_0_col      <= slot0_reg.x;
        sprite_0_attr     <= slot0_reg.attr;
        sprite_1_on_tile  <= slot1_v_reg;
        sprite_1_tile_num <= slot1_reg.tile;
        sprite_1_row      <= slot1_reg.y;
        sprite_1_col      <= slot1_reg.x;
        sprite_1_attr     <= slot1_reg.attr;
        sprite_overflow   <= ovf_reg;
      end
    end
  end

endmodule
